// File: rtl/usb_pkg.sv
// Shared types for the USB transaction engine: PID codes, packet kind, result code and FSM states.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        KIND_TOKEN = 2'd0,
        KIND_DATA  = 2'd1,
        KIND_HS    = 2'd2
    } tx_kind_t;

    typedef enum logic [1:0] {
        RES_OK        = 2'd0,
        RES_NAK_LIMIT = 2'd1,
        RES_STALL     = 2'd2,
        RES_ERR_LIMIT = 2'd3
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA_TX,
        ST_WAIT_HS,
        ST_WAIT_DATA,
        ST_SEND_ACK,
        ST_FINISH
    } state_t;

    function automatic logic [3:0] data_pid(input logic tog);
        return tog ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_timer.sv
// Response timer: counts while en, cleared by clr; expired is combinational on the count reaching CYCLES-1.
// No backpressure; the count saturates at CYCLES-1 and never wraps.
module usb_timer #(
    parameter int CYCLES = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = en && (r_cnt == W'(CYCLES - 1));

endmodule

// File: rtl/usb_xact_engine.sv
// Host-side USB transaction sequencer: token, data phase, handshake, with retries and per-endpoint DATA0/1 toggles.
// Each packet is held on tx_* until tx_ready; one-cycle done/result pulse after the final response or retry limit.
module usb_xact_engine
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 8,
    parameter int DATA_BYTES     = 8,
    parameter int NUM_EP         = 16
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        start,
    input  logic                        dir_in,
    input  logic [6:0]                  addr,
    input  logic [$clog2(NUM_EP)-1:0]   endp,
    input  logic [DATA_BYTES*8-1:0]     wdata,
    input  logic                        clr_toggle,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  result,
    output logic [DATA_BYTES*8-1:0]     rdata,
    output logic                        rdata_valid,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [1:0]                  tx_kind,
    output logic [3:0]                  tx_pid,
    output logic [6:0]                  tx_addr,
    output logic [3:0]                  tx_endp,
    output logic [DATA_BYTES*8-1:0]     tx_data,
    input  logic                        rx_valid,
    input  logic [3:0]                  rx_pid,
    input  logic [DATA_BYTES*8-1:0]     rx_data,
    input  logic                        rx_err
);
    localparam int DW    = DATA_BYTES * 8;
    localparam int EP_W  = $clog2(NUM_EP);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_dir_in;
    logic [6:0]        r_addr;
    logic [EP_W-1:0]   r_endp;
    logic [DW-1:0]     r_wdata;
    logic [DW-1:0]     r_rdata;
    logic [NUM_EP-1:0] r_toggle;
    logic [RTY_W-1:0]  r_retry;
    result_t           r_result;
    logic              r_deliver;

    logic     w_in_wait;
    logic     w_expired;
    logic     w_cur_tog;
    logic     w_fail;
    logic     w_nak;
    logic     w_flip;
    logic     w_capture;
    logic     w_retry_inc;
    logic     w_set_res;
    result_t  w_res;
    tx_kind_t w_kind;

    assign w_in_wait = (r_state == ST_WAIT_HS) || (r_state == ST_WAIT_DATA);
    assign w_cur_tog = r_toggle[r_endp];

    // Held clear outside the wait states, so every WAIT entry starts from zero.
    usb_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (!w_in_wait),
        .en      (w_in_wait),
        .expired (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_fail      = 1'b0;
        w_nak       = 1'b0;
        w_flip      = 1'b0;
        w_capture   = 1'b0;
        w_retry_inc = 1'b0;
        w_set_res   = 1'b0;
        w_res       = RES_OK;
        tx_valid    = 1'b0;
        w_kind      = KIND_TOKEN;
        tx_pid      = PID_OUT;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_TOKEN;
            end
            ST_TOKEN: begin
                tx_valid = 1'b1;
                tx_pid   = r_dir_in ? PID_IN : PID_OUT;
                if (tx_ready) w_next = r_dir_in ? ST_WAIT_DATA : ST_DATA_TX;
            end
            ST_DATA_TX: begin
                tx_valid = 1'b1;
                w_kind   = KIND_DATA;
                tx_pid   = data_pid(w_cur_tog);
                if (tx_ready) w_next = ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        w_fail = 1'b1;
                    end else begin
                        case (rx_pid)
                            PID_ACK: begin
                                w_flip    = 1'b1;
                                w_set_res = 1'b1;
                                w_res     = RES_OK;
                                w_next    = ST_FINISH;
                            end
                            PID_NAK:   w_nak = 1'b1;
                            PID_STALL: begin
                                w_set_res = 1'b1;
                                w_res     = RES_STALL;
                                w_next    = ST_FINISH;
                            end
                            default:   w_fail = 1'b1;
                        endcase
                    end
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        w_fail = 1'b1;
                    end else begin
                        case (rx_pid)
                            PID_NAK:   w_nak = 1'b1;
                            PID_STALL: begin
                                w_set_res = 1'b1;
                                w_res     = RES_STALL;
                                w_next    = ST_FINISH;
                            end
                            PID_DATA0, PID_DATA1: begin
                                // A toggle mismatch is a retransmission we already hold: ACK it, keep old data.
                                if (rx_pid == data_pid(w_cur_tog)) begin
                                    w_capture = 1'b1;
                                    w_flip    = 1'b1;
                                end
                                w_next = ST_SEND_ACK;
                            end
                            default:   w_fail = 1'b1;
                        endcase
                    end
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            ST_SEND_ACK: begin
                tx_valid = 1'b1;
                w_kind   = KIND_HS;
                tx_pid   = PID_ACK;
                if (tx_ready) begin
                    w_set_res = 1'b1;
                    w_res     = RES_OK;
                    w_next    = ST_FINISH;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase

        if (w_fail || w_nak) begin
            if (r_retry < RTY_W'(MAX_RETRIES)) begin
                w_retry_inc = 1'b1;
                w_next      = ST_TOKEN;
            end else begin
                w_set_res = 1'b1;
                w_res     = w_nak ? RES_NAK_LIMIT : RES_ERR_LIMIT;
                w_next    = ST_FINISH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_dir_in  <= 1'b0;
            r_addr    <= '0;
            r_endp    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_toggle  <= '0;
            r_retry   <= '0;
            r_result  <= RES_OK;
            r_deliver <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_dir_in  <= dir_in;
                r_addr    <= addr;
                r_endp    <= endp;
                r_wdata   <= wdata;
                r_retry   <= '0;
                r_deliver <= 1'b0;
            end
            if (w_retry_inc) r_retry <= r_retry + RTY_W'(1);
            if (w_set_res)   r_result <= w_res;
            if (w_capture) begin
                r_rdata   <= rx_data;
                r_deliver <= 1'b1;
            end
            if (r_state == ST_IDLE && clr_toggle) begin
                r_toggle <= '0;
            end else if (w_flip) begin
                r_toggle[r_endp] <= ~r_toggle[r_endp];
            end
        end
    end

    assign busy        = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done        = (r_state == ST_FINISH);
    assign result      = r_result;
    assign rdata       = r_rdata;
    assign rdata_valid = done && r_deliver;
    assign tx_kind     = w_kind;
    assign tx_addr     = r_addr;
    assign tx_endp     = 4'(r_endp);
    assign tx_data     = r_wdata;

endmodule
